// File: rtl/bno055_sample_assembler_if.sv
// Byte stream from the BNO055 I2C driver into the sample assembler.
// burst_start marks the next accepted byte as register 0x1A.
interface bno055_sample_assembler_if;
    logic       burst_start;
    logic [7:0] byte_in;
    logic       byte_valid;

    modport master (
        output burst_start,
        output byte_in,
        output byte_valid
    );

    modport slave (
        input burst_start,
        input byte_in,
        input byte_valid
    );
endinterface

// File: rtl/bno055_sample_assembler.sv
// Assembles a 20-byte BNO055 burst (0x1A..0x2D) into signed words, published atomically.
// Optional heading re-zeroing is enabled by defining BNO055_HEADING_ZERO_EN.
module bno055_sample_assembler #(
    parameter int BURST_LEN      = 20,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef BNO055_HEADING_ZERO_EN
    input  logic                 zero_req,
`endif
    bno055_sample_assembler_if.slave rx,
    output logic [15:0]          heading,
    output logic [15:0]          roll,
    output logic [15:0]          pitch,
    output logic [15:0]          quat_w,
    output logic [15:0]          quat_x,
    output logic [15:0]          quat_y,
    output logic [15:0]          quat_z,
    output logic [15:0]          lia_x,
    output logic [15:0]          lia_y,
    output logic [15:0]          lia_z,
    output logic                 sample_valid,
    output logic                 burst_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     good_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int NW = BURST_LEN / 2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]    LAST_IDX = 5'(BURST_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    generate
        if (BURST_LEN != 20) begin : g_len_chk
            $error("BURST_LEN must be 20");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d, wr_idx;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        shd_q [BURST_LEN];
    logic [7:0]        shd_d [BURST_LEN];
    logic [15:0]       pub_q [NW];
    logic [15:0]       pub_d [NW];
    logic [CNT_W-1:0]  good_q, good_d, err_q, err_d;
    logic              err_pulse_q, err_pulse_d;
    logic              store, abort, commit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        shd_d   = shd_q;
        pub_d   = pub_q;
        good_d  = good_q;
        err_d   = err_q;
        store   = 1'b0;
        abort   = 1'b0;
        commit  = 1'b0;
        wr_idx  = rx.burst_start ? 5'd0 : idx_q;

        unique case (state_q)
            COLLECT: begin
                tmo_d = tmo_q + TW'(1);
                if (rx.burst_start) begin
                    abort = 1'b1;
                    store = rx.byte_valid;
                    tmo_d = '0;
                end else if (rx.byte_valid) begin
                    store  = 1'b1;
                    tmo_d  = '0;
                    commit = (idx_q == LAST_IDX);
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            default: begin
                // IDLE and COMMIT both accept a new burst start
                if (rx.burst_start) begin
                    state_d = COLLECT;
                    store   = rx.byte_valid;
                    tmo_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (rx.burst_start) idx_d = '0;

        if (store) begin
            shd_d[wr_idx] = rx.byte_in;
            idx_d         = wr_idx + 5'd1;
        end

        if (commit) begin
            state_d = COMMIT;
            idx_d   = '0;
            for (int k = 0; k < NW; k++) begin
                pub_d[k] = {shd_d[2*k+1], shd_d[2*k]};
            end
            if (~&good_q) good_d = good_q + CNT_W'(1);
        end

        if (abort && ~&err_q) err_d = err_q + CNT_W'(1);
        err_pulse_d = abort;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            good_q      <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
            for (int i = 0; i < BURST_LEN; i++) shd_q[i] <= '0;
            for (int i = 0; i < NW; i++) pub_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            good_q      <= good_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            shd_q       <= shd_d;
            pub_q       <= pub_d;
        end
    end

`ifdef BNO055_HEADING_ZERO_EN
    logic [15:0] off_q, off_d, raw_clip;

    // zero_req applies immediately so a same-cycle commit reads as 0
    always_comb begin
        raw_clip = (pub_q[0] >= 16'd5760) ? 16'd5759 : pub_q[0];
        off_d    = zero_req ? raw_clip : off_q;
        if (raw_clip >= off_d) heading = raw_clip - off_d;
        else heading = raw_clip + 16'd5760 - off_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) off_q <= '0;
        else off_q <= off_d;
    end
`else
    assign heading = pub_q[0];
`endif

    assign roll         = pub_q[1];
    assign pitch        = pub_q[2];
    assign quat_w       = pub_q[3];
    assign quat_x       = pub_q[4];
    assign quat_y       = pub_q[5];
    assign quat_z       = pub_q[6];
    assign lia_x        = pub_q[7];
    assign lia_y        = pub_q[8];
    assign lia_z        = pub_q[9];
    assign sample_valid = (state_q == COMMIT);
    assign busy         = (state_q == COLLECT);
    assign burst_err    = err_pulse_q;
    assign good_cnt     = good_q;
    assign err_cnt      = err_q;
endmodule

// File: doc/bno055_sample_assembler.md
Name: bno055_sample_assembler

Overview:
- Downstream consumer of the BNO055 I2C driver's received-byte stream.
- Collects one 20-byte burst read starting at register 0x1A: Euler 0x1A–0x1F, quaternion 0x20–0x27, linear accel 0x28–0x2D, all little-endian.
- Assembles the bytes into signed 16-bit words and publishes them atomically, with one valid strobe per complete sample, to flight-control logic.
- Detects truncated or stalled bursts and discards them.

Parameters:
- BURST_LEN, 20, bytes per sample burst; fixed layout above; legal values 20 only, assert otherwise.
- TIMEOUT_CYCLES, 50000, max clk cycles between consecutive bytes inside a burst before abort.
- CNT_W, 16, width of good/error sample counters.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- burst_start  input  1  one-cycle pulse; next accepted byte (or a byte in the same cycle) is index 0.
- byte_in  input  8  received data byte from the driver.
- byte_valid  input  1  byte_in is valid this cycle.
- heading, roll, pitch  output  16 each  Euler, signed, 16 LSB/deg.
- quat_w, quat_x, quat_y, quat_z  output  16 each  quaternion, signed, 2^14 LSB.
- lia_x, lia_y, lia_z  output  16 each  linear acceleration, signed, 100 LSB/(m/s²).
- sample_valid  output  1  one-cycle pulse when all outputs update.
- burst_err  output  1  one-cycle pulse on aborted burst.
- busy  output  1  high while in COLLECT.
- good_cnt, err_cnt  output  CNT_W  saturating counters.

Behaviour:
- Reset: all data outputs 0, sample_valid/burst_err/busy 0, counters 0, state IDLE, byte index 0, timeout counter 0. Reset mid-burst discards partial data; published outputs return to 0.
- State IDLE:
  - byte_valid without burst_start is ignored; no counter change.
  - burst_start goes to COLLECT with idx=0.
  - If byte_valid is also asserted in that cycle, the byte is stored as idx 0 and idx becomes 1.
- State COLLECT:
  - Each byte_valid stores byte_in into a shadow register at idx, then idx++ and the timeout counter clears.
  - Even idx is the LSB and odd idx the MSB of word idx/2.
  - Word order: heading, roll, pitch, w, x, y, z, lia_x, lia_y, lia_z.
  - When the byte at idx=BURST_LEN-1 is accepted, go to COMMIT.
- State COMMIT (one cycle):
  - Copy the shadow registers to the outputs and pulse sample_valid.
  - good_cnt++ (saturates at all-ones).
  - Return to IDLE.
  - Latency: sample_valid is high the cycle after the last byte is accepted; outputs are valid in that same cycle.
- Outputs are double-buffered. They never show a mix of old and new bursts and change only in COMMIT.
- Timeout: in COLLECT with no byte for TIMEOUT_CYCLES consecutive cycles:
  - Pulse burst_err, err_cnt++ (saturating), go to IDLE.
  - Outputs are unchanged.
- burst_start while in COLLECT (restart):
  - Counts as an abort: burst_err pulse, err_cnt++.
  - Stays in COLLECT with idx=0; a same-cycle byte_valid stores its byte as idx 0.
- byte_valid and burst_start both arrive in the COMMIT cycle: the commit completes and a new burst begins with that byte as idx 0.
- busy = (state==COLLECT).

Optional Feature:
- Macro BNO055_HEADING_ZERO_EN.
- When defined:
  - Adds input zero_req (1-bit pulse).
  - On zero_req, offset register ← currently published raw heading.
  - Published heading = raw − offset; if the result is < 0, add 5760. Result is always in 0..5759.
  - offset resets to 0.
  - zero_req in the same cycle as COMMIT captures the new raw heading, and that COMMIT publishes 0.
  - Raw heading values ≥ 5760 are clamped to 5759 before subtraction.
- When undefined: no zero_req port; heading is passed through raw.

Test Plan:
- Valid burst: burst_start + bytes 0x00..0x13, one every 3 cycles.
  - Response: heading=0x0100, roll=0x0302, …, lia_z=0x1312.
  - sample_valid pulses once, 1 cycle after byte 19; good_cnt=1.
- Stall: 7 bytes, then idle for TIMEOUT_CYCLES (parameter set to 100).
  - Response: burst_err pulse at cycle 100; err_cnt=1; outputs keep the previous sample.
- Restart: 10 bytes, then burst_start plus 20 bytes of 0xAA.
  - Response: err_cnt=1, all words 0xAAAA, good_cnt=1.
- Stray bytes in IDLE: 5 byte_valid pulses without burst_start.
  - Response: no strobes, counters unchanged.
- Reset mid-burst: rstn low after byte 12.
  - Response: all outputs 0 immediately (async). A subsequent full burst publishes correctly.
- With BNO055_HEADING_ZERO_EN:
  - Publish heading 1000 and pulse zero_req; next burst with heading 200 → heading=4960.
  - Next burst with heading 1000 → 0.
